// File: rtl/alu_operand_loader.sv
// alu_operand_loader
// Assembles {opcode, A, B} command frames from a byte stream for the ALU tile.
// Frame: header byte (SYNC nibble + opcode), then A and B, little-endian,
// WIDTH/8 bytes each. The completed frame is held on a valid/ready handshake.
// Bad headers, mid-frame timeouts and overruns raise sticky error flags.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for a header byte
//   LOAD_A | collecting operand A bytes, inter-byte timer running
//   LOAD_B | collecting operand B bytes, inter-byte timer running
//   ISSUE  | op_valid high, waiting for op_ready; new bytes are overruns

module alu_operand_loader #(
    parameter int         WIDTH   = 8,
    parameter logic [3:0] SYNC    = 4'hA,
    parameter int         TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             clr_err,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [3:0]       opcode,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             busy,
    output logic             err_hdr,
    output logic             err_tmo,
    output logic             err_ovr
);

    localparam int            NBYTES   = WIDTH / 8;
    localparam int            CW       = $clog2(NBYTES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);
    // Abort fires on the idle cycle that would bring the timer to TIMEOUT.
    localparam logic [15:0]   TMR_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        ISSUE  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   timer;

    // busy reflects the state register directly
    assign busy = (state != IDLE);

    // Frame assembly FSM, operand registers, timer and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            timer    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            opcode   <= '0;
            op_valid <= 1'b0;
            err_hdr  <= 1'b0;
            err_tmo  <= 1'b0;
            err_ovr  <= 1'b0;
        end else begin
            // Clear first; any set below overrides it in the same cycle.
            if (clr_err) begin
                err_hdr <= 1'b0;
                err_tmo <= 1'b0;
                err_ovr <= 1'b0;
            end

            if (ena) begin
                case (state)
                    IDLE: begin
                        if (byte_valid) begin
                            if (byte_in[7:4] == SYNC) begin
                                opcode <= byte_in[3:0];
                                cnt    <= '0;
                                timer  <= '0;
                                state  <= LOAD_A;
                            end else begin
                                err_hdr <= 1'b1;
                            end
                        end
                    end

                    LOAD_A: begin
                        if (byte_valid) begin
                            for (int i = 0; i < NBYTES; i++) begin
                                if (cnt == CW'(i)) op_a[8*i +: 8] <= byte_in;
                            end
                            timer <= '0;
                            if (cnt == CNT_LAST) begin
                                cnt   <= '0;
                                state <= LOAD_B;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else if (timer == TMR_LAST) begin
                            err_tmo <= 1'b1;
                            timer   <= '0;
                            cnt     <= '0;
                            state   <= IDLE;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end

                    LOAD_B: begin
                        if (byte_valid) begin
                            for (int i = 0; i < NBYTES; i++) begin
                                if (cnt == CW'(i)) op_b[8*i +: 8] <= byte_in;
                            end
                            timer <= '0;
                            if (cnt == CNT_LAST) begin
                                cnt      <= '0;
                                op_valid <= 1'b1;
                                state    <= ISSUE;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else if (timer == TMR_LAST) begin
                            err_tmo <= 1'b1;
                            timer   <= '0;
                            cnt     <= '0;
                            state   <= IDLE;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end

                    ISSUE: begin
                        // Frames are not queued: a byte here is dropped even
                        // when the handshake completes in the same cycle.
                        if (byte_valid) err_ovr <= 1'b1;
                        if (op_ready) begin
                            op_valid <= 1'b0;
                            state    <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: an 8-bit and a 16-bit instance share the
// stimulus; each test selects which instance's outputs are checked and
// resets both beforehand. Completed frames are scored through a queue.

module tb_alu_operand_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       clr_err = 1'b0;
    logic       op_ready = 1'b0;

    logic [7:0]  a8, b8;
    logic [3:0]  opc8;
    logic        v8, busy8, eh8, et8, eo8;
    logic [15:0] a16, b16;
    logic [3:0]  opc16;
    logic        v16, busy16, eh16, et16, eo16;

    bit          w16 = 1'b0;
    logic [15:0] s_a, s_b;
    logic [3:0]  s_opc;
    logic        s_v, s_busy, s_eh, s_et, s_eo;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        bit          wide;
        logic [3:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        int          hold;
    } vec_t;

    always #5 clk = ~clk;

    alu_operand_loader #(.WIDTH(8), .SYNC(4'hA), .TIMEOUT(4)) u_dut8 (
        .clk(clk), .rst(rst), .ena(ena), .byte_in(byte_in), .byte_valid(byte_valid),
        .clr_err(clr_err), .op_a(a8), .op_b(b8), .opcode(opc8), .op_valid(v8),
        .op_ready(op_ready), .busy(busy8), .err_hdr(eh8), .err_tmo(et8), .err_ovr(eo8)
    );

    alu_operand_loader #(.WIDTH(16), .SYNC(4'hA), .TIMEOUT(4)) u_dut16 (
        .clk(clk), .rst(rst), .ena(ena), .byte_in(byte_in), .byte_valid(byte_valid),
        .clr_err(clr_err), .op_a(a16), .op_b(b16), .opcode(opc16), .op_valid(v16),
        .op_ready(op_ready), .busy(busy16), .err_hdr(eh16), .err_tmo(et16), .err_ovr(eo16)
    );

    always_comb begin
        if (w16) begin
            s_a = a16; s_b = b16; s_opc = opc16; s_v = v16;
            s_busy = busy16; s_eh = eh16; s_et = et16; s_eo = eo16;
        end else begin
            s_a = {8'h00, a8}; s_b = {8'h00, b8}; s_opc = opc8; s_v = v8;
            s_busy = busy8; s_eh = eh8; s_et = et8; s_eo = eo8;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input bit wide, input logic [3:0] opc,
                              input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        w16 = wide;
        send({4'hA, opc});
        send(a[7:0]);
        if (wide) send(a[15:8]);
        send(b[7:0]);
        if (wide) send(b[15:8]);
        e.opc = opc;
        e.a   = wide ? a : {8'h00, a[7:0]};
        e.b   = wide ? b : {8'h00, b[7:0]};
        sbq.push_back(e);
    endtask

    // Raise op_ready, wait (bounded) for op_valid, score the frame, confirm drop.
    task automatic handshake(input string tag);
        exp_t e;
        int n = 0;
        op_ready = 1'b1;
        while (!s_v && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, s_v, 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check({tag, "_opcode"}, s_opc, e.opc);
            check({tag, "_op_a"}, s_a, e.a);
            check({tag, "_op_b"}, s_b, e.b);
        end else begin
            check({tag, "_sb_underflow"}, sbq.size(), 1);
        end
        tick();
        op_ready = 1'b0;
        check({tag, "_valid_drop"}, s_v, 0);
        check({tag, "_busy_drop"}, s_busy, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        apply_reset();
        op_ready = (v.hold == 0);
        send_frame(v.wide, v.opc, v.a, v.b);
        check({tag, "_latency"}, s_v, 1);
        for (int i = 0; i < v.hold; i++) begin
            check({tag, "_hold_valid"}, s_v, 1);
            check({tag, "_hold_a"}, s_a, v.wide ? v.a : {8'h00, v.a[7:0]});
            check({tag, "_hold_b"}, s_b, v.wide ? v.b : {8'h00, v.b[7:0]});
            tick();
        end
        handshake(tag);
        check({tag, "_no_tmo"}, s_et, 0);
    endtask

    vec_t vecs[5];
    exp_t e;

    initial begin
        vecs[0] = '{wide: 1'b0, opc: 4'h3, a: 16'h0012, b: 16'h0034, hold: 0};
        vecs[1] = '{wide: 1'b0, opc: 4'hF, a: 16'h00FF, b: 16'h0000, hold: 2};
        vecs[2] = '{wide: 1'b1, opc: 4'h7, a: 16'hABCD, b: 16'h0001, hold: 5};
        vecs[3] = '{wide: 1'b1, opc: 4'h0, a: 16'h8001, b: 16'hFFFE, hold: 1};
        vecs[4] = '{wide: 1'b1, opc: 4'hC, a: 16'h1234, b: 16'h5678, hold: 0};

        // Reset state of both instances
        #2;
        for (int k = 0; k < 2; k++) begin
            w16 = (k == 1);
            #1;
            check("rst_busy", s_busy, 0);
            check("rst_valid", s_v, 0);
            check("rst_op_a", s_a, 0);
            check("rst_op_b", s_b, 0);
            check("rst_opcode", s_opc, 0);
            check("rst_errs", {s_eh, s_et, s_eo}, 0);
        end
        apply_reset();

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Bad header, clear, then a normal frame; set wins over clear
        apply_reset();
        w16 = 1'b0;
        send(8'h53);
        check("hdr_err", s_eh, 1);
        check("hdr_busy", s_busy, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("hdr_clr", s_eh, 0);
        op_ready = 1'b1;
        send_frame(1'b0, 4'h1, 16'h0010, 16'h0020);
        handshake("hdr_next");
        clr_err = 1'b1;
        send(8'h53);
        clr_err = 1'b0;
        check("hdr_set_wins", s_eh, 1);

        // Timeout after 4 idle cycles in LOAD_B, then a clean frame
        apply_reset();
        w16 = 1'b0;
        send(8'hA2);
        send(8'h55);
        tick(); tick(); tick();
        check("tmo_early", s_et, 0);
        check("tmo_early_busy", s_busy, 1);
        tick();
        check("tmo_err", s_et, 1);
        check("tmo_busy", s_busy, 0);
        check("tmo_valid", s_v, 0);
        op_ready = 1'b1;
        send_frame(1'b0, 4'h0, 16'h0001, 16'h0002);
        handshake("tmo_next");
        check("tmo_sticky", s_et, 1);

        // Byte arriving on the terminal timer cycle wins
        apply_reset();
        w16 = 1'b0;
        send(8'hA2);
        send(8'h55);
        tick(); tick(); tick();
        send(8'h66);
        check("tmo_byte_wins_err", s_et, 0);
        check("tmo_byte_wins_valid", s_v, 1);
        check("tmo_byte_wins_b", s_b, 16'h0066);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;

        // Overrun while waiting in ISSUE
        apply_reset();
        op_ready = 1'b0;
        send_frame(1'b1, 4'h5, 16'h2211, 16'h4433);
        check("ovr_valid", s_v, 1);
        send(8'hA9);
        check("ovr_err", s_eo, 1);
        check("ovr_valid_held", s_v, 1);
        check("ovr_op_a", s_a, 16'h2211);
        check("ovr_op_b", s_b, 16'h4433);
        check("ovr_opcode", s_opc, 4'h5);
        handshake("ovr");

        // Header coincident with the handshake is an overrun, not a new frame
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovr_clr", s_eo, 0);
        send_frame(1'b1, 4'h6, 16'h0F0E, 16'h0D0C);
        e = sbq.pop_front();
        check("ovr2_opcode", s_opc, e.opc);
        check("ovr2_op_a", s_a, e.a);
        check("ovr2_op_b", s_b, e.b);
        op_ready = 1'b1;
        send(8'hA9);
        op_ready = 1'b0;
        check("ovr2_valid", s_v, 0);
        check("ovr2_err", s_eo, 1);
        tick();
        check("ovr2_idle", s_busy, 0);

        // Async reset during LOAD_B and during ISSUE
        apply_reset();
        w16 = 1'b1;
        send(8'hA4); send(8'h01); send(8'h02); send(8'h03);
        check("rstb_busy_before", s_busy, 1);
        rst = 1'b1;
        #1;
        check("rstb_busy", s_busy, 0);
        check("rstb_op_a", s_a, 0);
        check("rstb_opcode", s_opc, 0);
        tick();
        rst = 1'b0;
        send_frame(1'b1, 4'h8, 16'h1357, 16'h2468);
        check("rsti_valid_before", s_v, 1);
        rst = 1'b1;
        #1;
        check("rsti_valid", s_v, 0);
        check("rsti_busy", s_busy, 0);
        check("rsti_ops", {s_opc, s_a, s_b}, 0);
        sbq.delete();
        tick();
        rst = 1'b0;

        // ena=0 freezes the timer and ignores bytes
        apply_reset();
        w16 = 1'b1;
        send(8'hA3);
        send(8'h10);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            byte_in = 8'hEE;
            byte_valid = (i % 2 == 1);
            tick();
        end
        byte_valid = 1'b0;
        ena = 1'b1;
        check("ena_busy", s_busy, 1);
        check("ena_no_tmo", s_et, 0);
        send(8'h20); send(8'h30); send(8'h40);
        e.opc = 4'h3; e.a = 16'h2010; e.b = 16'h4030;
        sbq.push_back(e);
        handshake("ena");

        check("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
